// File: rtl/tl_sync_fifo_pkg.sv
// Shared helpers and types for the single-clock TileLink beat FIFO.
// Holds width/pointer helpers and the status payload seen by upstream monitors.
package tl_fifo_pkg;

    localparam int unsigned STATUS_CNT_W = 8;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Wrap by compare so non-power-of-two depths index correctly
    function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

    typedef struct packed {
        logic [STATUS_CNT_W-1:0] count;
        logic                    almost_full;
        logic                    almost_empty;
    } tl_fifo_status_t;

endpackage

// File: rtl/tl_sync_fifo_if.sv
// Producer/consumer handshake bundle for tl_sync_fifo, including flush and status.
// slave = the FIFO, master = the agent driving it.
interface tl_sync_fifo_if
    import tl_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8
) ();
    localparam int unsigned CNT_W = cnt_width(DEPTH);

    logic                  flush;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;
    logic [CNT_W-1:0]      count;
    logic                  almost_full;
    logic                  almost_empty;

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count, almost_full, almost_empty
    );

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count, almost_full, almost_empty
    );
endinterface

// File: rtl/tl_sync_fifo_mem.sv
// FIFO storage: register array with one write port and one asynchronous read port.
// No reset on the array; contents are only meaningful behind the pointers.
module tl_fifo_mem #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    localparam int unsigned AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/tl_sync_fifo.sv
// Single-clock valid/ready FIFO with fill level, almost-full/empty flags and flush.
// Optional zero-latency bypass on an empty FIFO: define TL_FIFO_BYPASS_EN.
module tl_sync_fifo
    import tl_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned AF_LEVEL   = DEPTH - 2,
    parameter int unsigned AE_LEVEL   = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    tl_sync_fifo_if.slave  bus
);
    localparam int unsigned CNT_W = cnt_width(DEPTH);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  empty;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  pass;
    logic                  wr_en;
    logic                  rd_en;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    assign bus.in_ready = !full && !bus.flush;

`ifdef TL_FIFO_BYPASS_EN
    logic byp_c;
    // Empty FIFO forwards the producer beat straight to the consumer
    assign byp_c         = empty && !bus.flush;
    assign bus.out_valid = byp_c ? bus.in_valid : (!empty && !bus.flush);
    assign bus.out_data  = byp_c ? bus.in_data  : rdata;
    assign pass          = byp_c && bus.in_valid && bus.out_ready;
`else
    assign bus.out_valid = !empty && !bus.flush;
    assign bus.out_data  = rdata;
    assign pass          = 1'b0;
`endif

    assign push  = bus.in_valid && bus.in_ready;
    assign pop   = bus.out_valid && bus.out_ready;
    assign wr_en = push && !pass;
    assign rd_en = pop && !pass;

    assign bus.count        = count;
    assign bus.almost_full  = (count >= CNT_W'(AF_LEVEL));
    assign bus.almost_empty = (count <= CNT_W'(AE_LEVEL));

    // Pointers and fill level; flush wins over any handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= PTR_W'(ptr_next(32'(wr_ptr), DEPTH));
            if (rd_en) rd_ptr <= PTR_W'(ptr_next(32'(rd_ptr), DEPTH));
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    tl_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (bus.in_data),
        .raddr (rd_ptr),
        .rdata (rdata)
    );
endmodule

// File: tb/tb_tl_sync_fifo.sv
// Scoreboard bench for tl_sync_fifo: DEPTH=8 main instance plus a DEPTH=5 wrap instance.
// Honours TL_FIFO_BYPASS_EN for the latency expectations.
module tb_tl_sync_fifo;
    import tl_fifo_pkg::*;

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [31:0] sb8 [$];
    logic [7:0]  sb5 [$];
    logic [31:0] exp8;
    logic [7:0]  exp5;

    tl_sync_fifo_if #(.DATA_WIDTH(32), .DEPTH(8)) b8 ();
    tl_sync_fifo_if #(.DATA_WIDTH(8),  .DEPTH(5)) b5 ();

    tl_sync_fifo #(.DATA_WIDTH(32), .DEPTH(8)) dut8 (.clk(clk), .reset_n(rst_n), .bus(b8));
    tl_sync_fifo #(.DATA_WIDTH(8),  .DEPTH(5)) dut5 (.clk(clk), .reset_n(rst_n), .bus(b5));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Output monitors: a beat leaves whenever out_valid && out_ready is seen mid-cycle
    always @(negedge clk) begin
        if (rst_n && b8.out_valid && b8.out_ready) begin
            n_tests++;
            if (sb8.size() == 0) begin
                n_fail++;
                $display("FAIL d8_beat: got %h, required no beat", b8.out_data);
            end else begin
                exp8 = sb8.pop_front();
                if (b8.out_data !== exp8) begin
                    n_fail++;
                    $display("FAIL d8_beat: got %h, required %h", b8.out_data, exp8);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b5.out_valid && b5.out_ready) begin
            n_tests++;
            if (sb5.size() == 0) begin
                n_fail++;
                $display("FAIL d5_beat: got %h, required no beat", b5.out_data);
            end else begin
                exp5 = sb5.pop_front();
                if (b5.out_data !== exp5) begin
                    n_fail++;
                    $display("FAIL d5_beat: got %h, required %h", b5.out_data, exp5);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        b8.flush = 1'b0; b8.in_valid = 1'b0; b8.in_data = '0; b8.out_ready = 1'b0;
        b5.flush = 1'b0; b5.in_valid = 1'b0; b5.in_data = '0; b5.out_ready = 1'b0;
        repeat (2) step();

        chk("rst_in_ready",  int'(b8.in_ready),     1);
        chk("rst_out_valid", int'(b8.out_valid),    0);
        chk("rst_count",     int'(b8.count),        0);
        chk("rst_af",        int'(b8.almost_full),  0);
        chk("rst_ae",        int'(b8.almost_empty), 1);
        rst_n = 1'b1;

        // Fill 0xA0..0xA7 with the consumer stalled
        for (int i = 0; i < 8; i++) begin
            b8.in_valid = 1'b1;
            b8.in_data  = 32'(32'hA0 + i);
            #1;
            chk("fill_in_ready", int'(b8.in_ready), 1);
            sb8.push_back(32'(32'hA0 + i));
            step();
            chk("fill_count", int'(b8.count), i + 1);
            chk("fill_af", int'(b8.almost_full),  (i + 1 >= 6) ? 1 : 0);
            chk("fill_ae", int'(b8.almost_empty), (i + 1 <= 2) ? 1 : 0);
        end
        b8.in_data = 32'hA8;
        #1;
        chk("full_in_ready", int'(b8.in_ready), 0);
        step();
        chk("full_hold_count", int'(b8.count), 8);

        // Full with simultaneous pop: pop accepted, push refused
        b8.out_ready = 1'b1;
        #1;
        chk("fullpop_in_ready",  int'(b8.in_ready),  0);
        chk("fullpop_out_valid", int'(b8.out_valid), 1);
        step();
        chk("fullpop_count", int'(b8.count), 7);
        chk("retry_in_ready", int'(b8.in_ready), 1);
        sb8.push_back(32'hA8);
        step();
        chk("pushpop_count", int'(b8.count), 7);
        b8.in_valid = 1'b0;

        // Drain A2..A8
        for (int k = 7; k >= 1; k--) begin
            #1;
            chk("drain_count", int'(b8.count), k);
            chk("drain_ae", int'(b8.almost_empty), (k <= 2) ? 1 : 0);
            chk("drain_af", int'(b8.almost_full),  (k >= 6) ? 1 : 0);
            step();
        end
        chk("drained_count",     int'(b8.count),     0);
        chk("drained_out_valid", int'(b8.out_valid), 0);
        chk("drained_sb",        sb8.size(),         0);

        // Flush at count 4 with both handshakes requested
        b8.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b8.in_valid = 1'b1;
            b8.in_data  = 32'(32'hB0 + i);
            sb8.push_back(32'(32'hB0 + i));
            step();
        end
        chk("preflush_count", int'(b8.count), 4);
        b8.flush = 1'b1; b8.in_data = 32'h77; b8.out_ready = 1'b1;
        #1;
        chk("flush_in_ready",  int'(b8.in_ready),  0);
        chk("flush_out_valid", int'(b8.out_valid), 0);
        sb8.delete();
        step();
        b8.flush = 1'b0; b8.in_valid = 1'b0; b8.out_ready = 1'b0;
        #1;
        chk("postflush_count",     int'(b8.count),     0);
        chk("postflush_out_valid", int'(b8.out_valid), 0);
        b8.in_valid = 1'b1; b8.in_data = 32'h55;
        sb8.push_back(32'h55);
        step();
        b8.in_valid = 1'b0; b8.out_ready = 1'b1;
        #1;
        chk("p55_out_valid", int'(b8.out_valid), 1);
        step();
        chk("p55_count", int'(b8.count), 0);

        // Empty FIFO, producer and consumer both ready
        b8.in_valid = 1'b1; b8.in_data = 32'h3C; b8.out_ready = 1'b1;
        sb8.push_back(32'h3C);
        #1;
`ifdef TL_FIFO_BYPASS_EN
        chk("byp_out_valid", int'(b8.out_valid), 1);
        step();
        b8.in_valid = 1'b0;
        chk("byp_count", int'(b8.count), 0);
`else
        chk("nobyp_out_valid", int'(b8.out_valid), 0);
        step();
        b8.in_valid = 1'b0;
        chk("nobyp_count", int'(b8.count), 1);
        #1;
        chk("nobyp_next_valid", int'(b8.out_valid), 1);
        step();
        chk("nobyp_after_count", int'(b8.count), 0);
`endif
        b8.out_ready = 1'b0;

        // DEPTH=5: 13 pushes interleaved with pops, bench model tracks fill level
        begin
            int  mc = 0;
            int  sent = 0;
            int  cyc = 0;
            bit  iv, ordy, pu, po;
            while (!(sent == 13 && mc == 0) && cyc < 80) begin
                iv   = (sent < 13);
                ordy = (cyc < 6) ? 1'b0 : (cyc % 3 != 0);
                b5.in_valid  = iv;
                b5.in_data   = 8'(8'h10 + sent);
                b5.out_ready = ordy;
                #1;
                chk("d5_count",     int'(b5.count),     mc);
                chk("d5_in_ready",  int'(b5.in_ready),  (mc != 5) ? 1 : 0);
                chk("d5_out_valid", int'(b5.out_valid), (mc != 0) ? 1 : 0);
                pu = iv && (mc != 5);
                po = (mc != 0) && ordy;
                if (pu) begin
                    sb5.push_back(8'(8'h10 + sent));
                    sent++;
                end
                mc = mc + int'(pu) - int'(po);
                cyc++;
                step();
            end
            b5.in_valid = 1'b0; b5.out_ready = 1'b0;
            n_tests++;
            if (cyc >= 80) begin
                n_fail++;
                $display("FAIL d5_timeout: got %0d cycles, required under 80", cyc);
            end
            chk("d5_sb_empty", sb5.size(), 0);
        end

        // Asynchronous reset between edges mid-burst
        b8.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b8.in_valid = 1'b1;
            b8.in_data  = 32'(32'hC0 + i);
            sb8.push_back(32'(32'hC0 + i));
            step();
        end
        b8.in_data = 32'hC3;
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_count",     int'(b8.count),     0);
        chk("arst_out_valid", int'(b8.out_valid), 0);
        chk("arst_in_ready",  int'(b8.in_ready),  1);
        sb8.delete();
        b8.in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        // First beat after reset release
        b8.in_valid = 1'b1; b8.in_data = 32'hD0; b8.out_ready = 1'b1;
        sb8.push_back(32'hD0);
        step();
        b8.in_valid = 1'b0;
        step();
        step();
        chk("final_count", int'(b8.count), 0);
        chk("final_sb",    sb8.size(),     0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
